// File: rtl/regfile_fifo_pkg.sv
// regfile_fifo_pkg: shared constants and types for the register-file FIFO controller.
//   DATA_W   - register-file word width
//   ADDR_W   - register-file address width, DEPTH = 2**ADDR_W entries
//   AF_LEVEL - almost-full threshold (REGFILE_FIFO_ALMOST_FLAGS_EN builds only)
//   AE_LEVEL - almost-empty threshold (REGFILE_FIFO_ALMOST_FLAGS_EN builds only)
package regfile_fifo_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned AF_LEVEL = 28;
  localparam int unsigned AE_LEVEL = 4;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;
  typedef logic [ADDR_W:0]   fifo_cnt_t;

endpackage : regfile_fifo_pkg

// File: rtl/regfile_fifo_ctrl_ptr.sv
// regfile_fifo_ptr: wrap-around register-file pointer.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, returns pointer to 0
//   inc_i  - advance pointer by one on the rising edge
//   ptr_o  - current pointer value (wraps modulo DEPTH)
import regfile_fifo_pkg::*;

module regfile_fifo_ptr (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     inc_i,
  output rf_addr_t ptr_o
);

  rf_addr_t ptr_q;
  rf_addr_t ptr_d;

  // Natural ADDR_W overflow gives the modulo-DEPTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + rf_addr_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule : regfile_fifo_ptr

// File: rtl/regfile_fifo_ctrl.sv
// regfile_fifo_ctrl: drives a 32x4 register-file BEL as a first-word-fall-through FIFO.
// Optional macro REGFILE_FIFO_ALMOST_FLAGS_EN adds registered almost_full/almost_empty.
// Ports:
//   UserCLK   - clock shared with the register file
//   RST       - synchronous active-high reset
//   push      - write request,  push_data - word to enqueue
//   pop       - read request,   pop_data  - head word (valid while empty=0)
//   full      - DEPTH entries held, empty - no entries held
//   count     - occupancy 0..DEPTH
//   RF_D, RF_W_ADR, RF_W_en - register-file write port
//   RF_A_ADR, RF_AD         - register-file read port A (combinational read)
//   almost_full, almost_empty - threshold flags (macro builds only)
import regfile_fifo_pkg::*;

module regfile_fifo_ctrl (
  input  logic      UserCLK,
  input  logic      RST,
  input  logic      push,
  input  rf_data_t  push_data,
  output logic      full,
  input  logic      pop,
  output rf_data_t  pop_data,
  output logic      empty,
  output fifo_cnt_t count,
  output rf_data_t  RF_D,
  output rf_addr_t  RF_W_ADR,
  output logic      RF_W_en,
  output rf_addr_t  RF_A_ADR,
  input  rf_data_t  RF_AD
`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
  ,
  output logic      almost_full,
  output logic      almost_empty
`endif
);

  fifo_cnt_t count_q;
  fifo_cnt_t count_d;
  rf_addr_t  wr_ptr;
  rf_addr_t  rd_ptr;
  logic      push_ok;
  logic      pop_ok;

  // Flags decode straight from the count register so they are never stale.
  assign full  = (count_q == fifo_cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO is legal when the same edge frees the head slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Occupancy update.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + fifo_cnt_t'(1);
      2'b01:   count_d = count_q - fifo_cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  regfile_fifo_ptr u_wr_ptr (
    .clk_i (UserCLK),
    .rst_i (RST),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  regfile_fifo_ptr u_rd_ptr (
    .clk_i (UserCLK),
    .rst_i (RST),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Write port: the register file captures on the accepting edge; reset blocks the write.
  assign RF_D     = push_data;
  assign RF_W_ADR = wr_ptr;
  assign RF_W_en  = push_ok & ~RST;

  // Read port: combinational head-of-FIFO (FWFT).
  assign RF_A_ADR = rd_ptr;
  assign pop_data = RF_AD;

  assign count = count_q;

`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
  logic almost_full_q;
  logic almost_empty_q;

  // Computed from next-state count so the flags line up with count.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= fifo_cnt_t'(AF_LEVEL));
      almost_empty_q <= (count_d <= fifo_cnt_t'(AE_LEVEL));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule : regfile_fifo_ctrl

// File: tb/tb_regfile_fifo_ctrl.sv
// tb_regfile_fifo_ctrl: self-checking bench for regfile_fifo_ctrl with a behavioural
// register-file model and a queue-based FIFO reference.
`timescale 1ns/1ps

module tb_regfile_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [3:0] push_data;
  logic       pop;
  logic       full;
  logic [3:0] pop_data;
  logic       empty;
  logic [5:0] count;
  logic [3:0] rf_d;
  logic [4:0] rf_w_adr;
  logic       rf_w_en;
  logic [4:0] rf_a_adr;
  logic [3:0] rf_ad;
`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queue contents plus totals of accepted pushes/pops since reset.
  logic [3:0] q[$];
  int unsigned wr_total;
  int unsigned rd_total;

  // Register-file BEL model: synchronous write, combinational read.
  logic [3:0] mem [32];
  always @(posedge clk) if (rf_w_en) mem[rf_w_adr] <= rf_d;
  assign rf_ad = mem[rf_a_adr];

  always #5 clk = ~clk;

  regfile_fifo_ctrl dut (
    .UserCLK   (clk),
    .RST       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .count     (count),
    .RF_D      (rf_d),
    .RF_W_ADR  (rf_w_adr),
    .RF_W_en   (rf_w_en),
    .RF_A_ADR  (rf_a_adr),
    .RF_AD     (rf_ad)
`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  function automatic bit m_pop_ok();
    return pop && !rst && q.size() > 0;
  endfunction

  function automatic bit m_push_ok();
    return push && !rst && (q.size() < 32 || m_pop_ok());
  endfunction

  // Apply inputs after the falling edge and let combinational outputs settle.
  task automatic drive(input bit p, input logic [3:0] d, input bit po, input bit r);
    @(negedge clk);
    push = p; push_data = d; pop = po; rst = r;
    #1;
  endtask

  // Advance the reference by one accepted edge, then take the edge.
  task automatic tick();
    bit pu, po;
    pu = m_push_ok();
    po = m_pop_ok();
    if (rst) begin
      q.delete();
      wr_total = 0;
      rd_total = 0;
    end else begin
      if (po) begin void'(q.pop_front()); rd_total++; end
      if (pu) begin q.push_back(push_data); wr_total++; end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(0, 4'h0, 0, 1); tick();
    drive(0, 4'h0, 0, 0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", rf_w_en); end
    n_checks++; if (rf_w_adr !== 5'd0 || rf_a_adr !== 5'd0) begin
      n_fail++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", rf_w_adr, rf_a_adr); end
    // Pop while empty is ignored.
    drive(0, 4'h0, 1, 0); tick();
    drive(0, 4'h0, 0, 0);
    n_checks++; if (count !== 6'd0 || rf_a_adr !== 5'd0) begin
      n_fail++; $display("FAIL pop_empty got count=%0d rd=%0d exp=0/0", count, rf_a_adr); end
  endtask

  task automatic test_basic();
    logic [3:0] vals [3];
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'h9;
    for (int i = 0; i < 3; i++) begin
      drive(1, vals[i], 0, 0);
      n_checks++; if (rf_w_en !== 1'b1 || rf_w_adr !== 5'(i)) begin
        n_fail++; $display("FAIL basic_write got en=%b adr=%0d exp=1/%0d", rf_w_en, rf_w_adr, i); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 1, 0);
      n_checks++; if (pop_data !== vals[i] || empty !== 1'b0) begin
        n_fail++; $display("FAIL basic_pop%0d got=%h empty=%b exp=%h/0", i, pop_data, empty, vals[i]); end
      tick();
    end
    drive(0, 4'h0, 0, 0);
    n_checks++; if (empty !== 1'b1 || count !== 6'd0) begin
      n_fail++; $display("FAIL basic_drained got empty=%b count=%0d exp=1/0", empty, count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) begin drive(1, 4'(i % 16), 0, 0); tick(); end
    drive(1, 4'hA, 0, 0);
    n_checks++; if (full !== 1'b1 || count !== 6'd32) begin
      n_fail++; $display("FAIL full_flag got full=%b count=%0d exp=1/32", full, count); end
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL full_push_ignored got wen=%b exp=0", rf_w_en); end
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(0, 4'h0, 1, 0);
      n_checks++; if (pop_data !== 4'(i % 16)) begin
        n_fail++; $display("FAIL full_order%0d got=%h exp=%h", i, pop_data, 4'(i % 16)); end
      tick();
    end
    drive(0, 4'h0, 0, 0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got empty=%b exp=1", empty); end
  endtask

  task automatic test_full_push_pop();
    drive(0, 4'h0, 0, 1); tick();
    for (int i = 0; i < 32; i++) begin drive(1, 4'(i % 16), 0, 0); tick(); end
    drive(1, 4'h7, 1, 0);
    n_checks++; if (rf_w_en !== 1'b1 || rf_w_adr !== 5'd0 || rf_a_adr !== 5'd0) begin
      n_fail++; $display("FAIL fpp_write got en=%b wadr=%0d radr=%0d exp=1/0/0", rf_w_en, rf_w_adr, rf_a_adr); end
    n_checks++; if (pop_data !== 4'h0) begin n_fail++; $display("FAIL fpp_head got=%h exp=0", pop_data); end
    tick();
    drive(0, 4'h0, 0, 0);
    n_checks++; if (count !== 6'd32 || full !== 1'b1) begin
      n_fail++; $display("FAIL fpp_count got=%0d full=%b exp=32/1", count, full); end
    for (int i = 0; i < 32; i++) begin
      logic [3:0] exp_v;
      exp_v = (i == 31) ? 4'h7 : 4'((i + 1) % 16);
      drive(0, 4'h0, 1, 0);
      n_checks++; if (pop_data !== exp_v) begin
        n_fail++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, pop_data, exp_v); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin drive(1, 4'(i + 1), 0, 0); tick(); end
    drive(1, 4'hC, 0, 1);
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen got=%b exp=0", rf_w_en); end
    tick();
    drive(1, 4'hE, 0, 0);
    n_checks++; if (count !== 6'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state got count=%0d empty=%b exp=0/1", count, empty); end
    n_checks++; if (rf_w_en !== 1'b1 || rf_w_adr !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_next got en=%b adr=%0d exp=1/0", rf_w_en, rf_w_adr); end
    tick();
    drive(0, 4'h0, 1, 0);
    n_checks++; if (pop_data !== 4'hE) begin n_fail++; $display("FAIL rstmid_head got=%h exp=e", pop_data); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit p, po, r;
      // Bias toward pushes in the first half and pops in the second to reach both ends.
      p  = ($urandom_range(99) < ((c < 300) ? 70 : 35));
      po = ($urandom_range(99) < ((c < 300) ? 35 : 70));
      r  = ($urandom_range(199) == 0);
      drive(p, 4'($urandom_range(15)), po, r);
      n_checks++; if (count !== 6'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 32)) begin
        n_fail++; $display("FAIL rnd_state c=%0d got count=%0d e=%b f=%b exp count=%0d", c, count, empty, full, q.size()); end
      n_checks++; if (rf_w_en !== m_push_ok()) begin
        n_fail++; $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, rf_w_en, m_push_ok()); end
      n_checks++; if (rf_w_adr !== 5'(wr_total % 32) || rf_a_adr !== 5'(rd_total % 32) || rf_d !== push_data) begin
        n_fail++; $display("FAIL rnd_ports c=%0d got w=%0d r=%0d exp w=%0d r=%0d", c, rf_w_adr, rf_a_adr, wr_total % 32, rd_total % 32); end
      if (q.size() > 0) begin
        n_checks++; if (pop_data !== q[0]) begin
          n_fail++; $display("FAIL rnd_head c=%0d got=%h exp=%h", c, pop_data, q[0]); end
      end
`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
      n_checks++; if (almost_full !== (q.size() >= 28) || almost_empty !== (q.size() <= 4)) begin
        n_fail++; $display("FAIL rnd_almost c=%0d got af=%b ae=%b size=%0d", c, almost_full, almost_empty, q.size()); end
`endif
      tick();
    end
  endtask

`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
  task automatic test_almost();
    drive(0, 4'h0, 0, 1); tick();
    for (int i = 0; i <= 32; i++) begin
      drive(i < 32, 4'($urandom_range(15)), 0, 0);
      n_checks++; if (almost_full !== (i >= 28) || almost_empty !== (i <= 4)) begin
        n_fail++; $display("FAIL almost_fill n=%0d got af=%b ae=%b", i, almost_full, almost_empty); end
      tick();
    end
    for (int i = 32; i >= 0; i--) begin
      drive(0, 4'h0, i > 0, 0);
      n_checks++; if (almost_full !== (i >= 28) || almost_empty !== (i <= 4)) begin
        n_fail++; $display("FAIL almost_drain n=%0d got af=%b ae=%b", i, almost_full, almost_empty); end
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 4'h0;
    wr_total = 0; rd_total = 0;
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_reset_mid();
    test_random();
`ifdef REGFILE_FIFO_ALMOST_FLAGS_EN
    test_almost();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_fifo_ctrl
